// File: rtl/integ_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : integ_gate_ctrl
// Purpose  : Event sequencer for the muon front-end pulse integrator.
// Revision : 1.0
// ============================================================================
module integ_gate_ctrl #(
    parameter int GATE_LEN    = 64,
    parameter int SETTLE_LEN  = 2,
    parameter int HOLDOFF_LEN = 16,
    parameter int TS_W        = 32,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             trig_in,
    output logic             int_clr,
    output logic             int_en,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [TS_W-1:0]  evt_ts,
    output logic             evt_pileup,
    output logic [CNT_W-1:0] evt_count,
    output logic [CNT_W-1:0] lost_count,
    output logic             busy
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_CLEAR   = 3'd1;
    localparam logic [2:0] c_GATE    = 3'd2;
    localparam logic [2:0] c_SETTLE  = 3'd3;
    localparam logic [2:0] c_VALID   = 3'd4;
    localparam logic [2:0] c_HOLDOFF = 3'd5;

    // Down-counter loads are length-1 so each phase lasts exactly its length.
    localparam logic [15:0] c_GATE_LOAD    = 16'(GATE_LEN - 1);
    localparam logic [15:0] c_SETTLE_LOAD  = 16'(SETTLE_LEN - 1);
    localparam logic [15:0] c_HOLDOFF_LOAD = 16'(HOLDOFF_LEN - 1);

    logic [2:0]       r_state;
    logic             r_trig_d;
    logic [TS_W-1:0]  r_ts;
    logic [15:0]      r_dly;
    logic [TS_W-1:0]  r_evt_ts;
    logic             r_pileup;
    logic [CNT_W-1:0] r_evt_cnt;
    logic [CNT_W-1:0] r_lost_cnt;

    logic w_edge;
    logic w_lost_inc;

    assign w_edge     = trig_in & ~r_trig_d;
    assign w_lost_inc = w_edge & (((r_state == c_IDLE) & ~enable) |
                                  (r_state == c_VALID) | (r_state == c_HOLDOFF));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_trig_d  <= 1'b0;
            r_ts      <= '0;
            r_dly     <= '0;
            r_evt_ts  <= '0;
            r_pileup  <= 1'b0;
            r_evt_cnt <= '0;
        end else begin
            r_trig_d <= trig_in;
            r_ts     <= r_ts + TS_W'(1);
            case (r_state)
                c_IDLE: begin
                    if (w_edge && enable) begin
                        r_state  <= c_CLEAR;
                        r_evt_ts <= r_ts;
                        r_pileup <= 1'b0;
                    end
                end
                c_CLEAR: begin
                    if (w_edge) r_pileup <= 1'b1;
                    r_state <= c_GATE;
                    r_dly   <= c_GATE_LOAD;
                end
                c_GATE: begin
                    if (w_edge) r_pileup <= 1'b1;
                    if (r_dly == '0) begin
                        r_state <= c_SETTLE;
                        r_dly   <= c_SETTLE_LOAD;
                    end else begin
                        r_dly <= r_dly - 16'd1;
                    end
                end
                c_SETTLE: begin
                    if (w_edge) r_pileup <= 1'b1;
                    if (r_dly == '0) r_state <= c_VALID;
                    else             r_dly   <= r_dly - 16'd1;
                end
                c_VALID: begin
                    if (evt_ready) begin
                        r_state   <= c_HOLDOFF;
                        r_dly     <= c_HOLDOFF_LOAD;
                        r_evt_cnt <= r_evt_cnt + CNT_W'(1);
                    end
                end
                c_HOLDOFF: begin
                    if (r_dly == '0) r_state <= c_IDLE;
                    else             r_dly   <= r_dly - 16'd1;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Lost-trigger counter saturates rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lost_cnt <= '0;
        end else if (w_lost_inc && (r_lost_cnt != {CNT_W{1'b1}})) begin
            r_lost_cnt <= r_lost_cnt + CNT_W'(1);
        end
    end

    assign int_clr    = (r_state == c_CLEAR);
    assign int_en     = (r_state == c_GATE);
    assign evt_valid  = (r_state == c_VALID);
    assign busy       = (r_state != c_IDLE);
    assign evt_ts     = r_evt_ts;
    assign evt_pileup = r_pileup;
    assign evt_count  = r_evt_cnt;
    assign lost_count = r_lost_cnt;

endmodule
`default_nettype wire
